parametric_instruction_cache: RTL and testbench
===============================================

Name: parametric_instruction_cache

Overview:
- Direct-mapped, read-only instruction cache between the fetch stage and the L2/memory interface.
- Successor to the fixed-width stub cache. Adds:
  - parametrised geometry (sets, words per line, address/data width)
  - a real tag/valid store
  - a miss-refill state machine with a valid/ready request handshake
  - a whole-cache FLUSH for fence.i
- Hit latency is one cycle. Misses stall fetch via INSTRUCTION_CACHE_READY until the line is refilled.

Parameters:
- ADDRESS_WIDTH, 32, PC/byte-address width.
- DATA_WIDTH, 32, instruction word width. Words are 4-byte aligned.
- LINE_WORDS, 4, words per cache line. Power of two, ≥2.
- SETS, 64, number of lines. Power of two, ≥2.
- HIGH, 1'b1, logic high constant.
- LOW, 1'b0, logic low constant.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset. One clock; reset is asynchronous and active-low.
- PC  in  ADDRESS_WIDTH  fetch byte address. Bits [1:0] are ignored.
- PC_VALID  in  1  PC holds a fetch request this cycle.
- INSTRUCTION_CACHE_STALL  in  1  downstream stall: hold the output and do not accept a new PC.
- FLUSH  in  1  single-cycle pulse; invalidate every line.
- INSTRUCTION  out  DATA_WIDTH  fetched instruction.
- INSTRUCTION_CACHE_READY  out  1  INSTRUCTION is valid for the PC accepted on the previous lookup.
- ADDRESS_TO_L2  out  ADDRESS_WIDTH  line-aligned refill address. Low log2(LINE_WORDS)+2 bits are zero.
- ADDRESS_TO_L2_VALID  out  1  refill request pending.
- ADDRESS_TO_L2_READY  in  1  L2 accepts the request.
- DATA_FROM_L2  in  DATA_WIDTH  refill beat.
- DATA_FROM_L2_VALID  in  1  beat valid. Exactly LINE_WORDS beats per request, word 0 first.

Behaviour:
- Address split:
  - OFFSET = PC[log2(LINE_WORDS)+1:2]
  - INDEX = next log2(SETS) bits
  - TAG = remaining upper bits, TAG_W = ADDRESS_WIDTH - log2(SETS) - log2(LINE_WORDS) - 2
- Reset (async, RST_N=0):
  - all valid bits cleared
  - state = IDLE
  - INSTRUCTION = 0, INSTRUCTION_CACHE_READY = 0
  - ADDRESS_TO_L2 = 0, ADDRESS_TO_L2_VALID = 0
  - beat counter = 0
  - Data and tag arrays are not reset.
  - Reset mid-refill abandons the refill. Later L2 beats are ignored because the state is IDLE.
- Accept: in IDLE, when PC_VALID=1 and STALL=0 at a rising edge, the PC is registered (lookup register).
- Stall: with STALL=1, the lookup register, INSTRUCTION and READY all hold their values. A refill already in progress continues.
- State IDLE, lookup register valid and hit (valid[INDEX] and tag match):
  - next edge: INSTRUCTION = data[INDEX][OFFSET], READY = 1
  - a new PC may be accepted on the same edge, giving back-to-back one-per-cycle hits.
- State IDLE, lookup register valid and miss:
  - READY = 0
  - go to REQUEST: ADDRESS_TO_L2 = line-aligned PC, ADDRESS_TO_L2_VALID = 1.
- REQUEST:
  - hold ADDRESS_TO_L2 and ADDRESS_TO_L2_VALID until ADDRESS_TO_L2_READY=1 at an edge.
  - on that edge: ADDRESS_TO_L2_VALID drops, go to REFILL, beat counter = 0.
- REFILL:
  - each edge with DATA_FROM_L2_VALID=1 writes data[INDEX][counter] and increments the counter.
  - on the last beat (counter = LINE_WORDS-1): write the tag, set valid[INDEX], go to RESPOND.
  - READY stays 0 throughout.
- RESPOND (one cycle): INSTRUCTION = the requested word, READY = 1, return to IDLE. No new PC is accepted in this cycle.
- PC_VALID=0 in IDLE: READY = 0 on the next edge. INSTRUCTION holds its last value.
- FLUSH:
  - in IDLE: clears all valid bits at the edge. A lookup registered in the same cycle evaluates as a miss.
  - in REQUEST or REFILL: latched as pending. The refill completes and the requested word is still delivered. All valid bits, including the new line, are cleared on entry to IDLE.
- Hit check uses the valid bit only after a refill completes. A partially refilled line is never a hit.
- Counter width is log2(LINE_WORDS). It does not wrap during a refill because it is cleared at the REQUEST→REFILL transition.

Decomposition:
- Package icache_pkg:
  - state enumeration: IDLE, REQUEST, REFILL, RESPOND
  - functions for offset, index and tag widths derived from the parameters
- One sub-module: icache_line_store. Holds the data array (SETS × LINE_WORDS × DATA_WIDTH, sync write, async read) and the tag array.
- Valid bits stay in the top-level module so that reset and flush apply in one place.

Test Plan:
- Reset, then PC=0x100 with PC_VALID=1 → miss, READY=0; ADDRESS_TO_L2=0x100, ADDRESS_TO_L2_VALID=1 until READY handshake; 4 beats 0xA0..0xA3 → RESPOND gives INSTRUCTION=0xA0, READY=1.
- After that refill, PCs 0x104, 0x108, 0x10C on consecutive cycles → INSTRUCTION 0xA1, 0xA2, 0xA3, one cycle each, READY held 1, no L2 request.
- PC=0x500, which maps to the same index as 0x100 with a different tag (default geometry) → miss; refill with 0xB0..0xB3; then PC=0x100 misses again (eviction).
- ADDRESS_TO_L2_READY held 0 for 5 cycles → ADDRESS_TO_L2_VALID stays 1 and the address stays stable; DATA_FROM_L2_VALID gapped between beats → counter advances only on valid beats.
- FLUSH pulse during the 2nd refill beat → word still delivered with READY=1; a following lookup of the same PC misses and re-requests the line.
- STALL=1 for 3 cycles after a hit → INSTRUCTION and READY held, new PC ignored; RST_N=0 mid-REFILL → ADDRESS_TO_L2_VALID=0, READY=0, and the previously cached 0x100 line misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared state encoding and geometry helpers for the instruction cache.
package icache_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      REFILL  = 2'd2,
      RESPOND = 2'd3
   } state_t;

   function automatic int offset_width(input int line_words);
      return $clog2(line_words);
   endfunction

   function automatic int index_width(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_width(input int address_width, input int sets, input int line_words);
      return address_width - $clog2(sets) - $clog2(line_words) - 2;
   endfunction

endpackage

// File: rtl/icache_line_store.sv
// Data and tag arrays: synchronous write, combinational read, no reset.
// Written one beat per cycle during refill; read every cycle by the lookup.
module icache_line_store
   import icache_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int LINE_WORDS = 4,
   parameter int SETS       = 64,
   parameter int TAG_W      = 22,
   localparam int OFF_W     = offset_width(LINE_WORDS),
   localparam int IDX_W     = index_width(SETS)
) (
   input  logic                  clk,
   input  logic                  data_we,
   input  logic [IDX_W-1:0]      wr_index,
   input  logic [OFF_W-1:0]      wr_offset,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  tag_we,
   input  logic [TAG_W-1:0]      wr_tag,
   input  logic [IDX_W-1:0]      rd_index,
   input  logic [OFF_W-1:0]      rd_offset,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [TAG_W-1:0]      rd_tag
);

   logic [DATA_WIDTH-1:0] data_mem [SETS][LINE_WORDS];
   logic [TAG_W-1:0]      tag_mem  [SETS];

   always_ff @(posedge clk) begin
      if (data_we) data_mem[wr_index][wr_offset] <= wr_data;
      if (tag_we)  tag_mem[wr_index]             <= wr_tag;
   end

   assign rd_data = data_mem[rd_index][rd_offset];
   assign rd_tag  = tag_mem[rd_index];

endmodule

// File: rtl/parametric_instruction_cache.sv
// Direct-mapped read-only instruction cache refilled a line at a time from L2.
// Hits answer one cycle after accept; misses hold READY low until the refilled word is delivered.
module parametric_instruction_cache
   import icache_pkg::*;
#(
   parameter int   ADDRESS_WIDTH = 32,
   parameter int   DATA_WIDTH    = 32,
   parameter int   LINE_WORDS    = 4,
   parameter int   SETS          = 64,
   parameter logic HIGH          = 1'b1,
   parameter logic LOW           = 1'b0
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic [ADDRESS_WIDTH-1:0] PC,
   input  logic                     PC_VALID,
   input  logic                     INSTRUCTION_CACHE_STALL,
   input  logic                     FLUSH,
   output logic [DATA_WIDTH-1:0]    INSTRUCTION,
   output logic                     INSTRUCTION_CACHE_READY,
   output logic [ADDRESS_WIDTH-1:0] ADDRESS_TO_L2,
   output logic                     ADDRESS_TO_L2_VALID,
   input  logic                     ADDRESS_TO_L2_READY,
   input  logic [DATA_WIDTH-1:0]    DATA_FROM_L2,
   input  logic                     DATA_FROM_L2_VALID
);

   localparam int OFF_W = offset_width(LINE_WORDS);
   localparam int IDX_W = index_width(SETS);
   localparam int TAG_W = tag_width(ADDRESS_WIDTH, SETS, LINE_WORDS);
   localparam int WA_W  = ADDRESS_WIDTH - 2;
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

   state_t state, state_nxt;

   logic [WA_W-1:0]       lk_addr;
   logic                  lk_vld;
   logic [SETS-1:0]       line_vld;
   logic                  flush_pend;
   logic [OFF_W-1:0]      beat_cnt;

   logic [OFF_W-1:0]      lk_off;
   logic [IDX_W-1:0]      lk_idx;
   logic [TAG_W-1:0]      lk_tag;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [TAG_W-1:0]      rd_tag;
   logic                  hit;

   logic lookup, do_hit, do_miss, accept, req_done, beat, last_beat, respond, flush_now;
   logic unused_pc_bits;

   assign unused_pc_bits = ^PC[1:0];

   assign lk_off = lk_addr[OFF_W-1:0];
   assign lk_idx = lk_addr[OFF_W +: IDX_W];
   assign lk_tag = lk_addr[WA_W-1 -: TAG_W];
   assign hit    = line_vld[lk_idx] && (rd_tag == lk_tag);

   icache_line_store #(
      .DATA_WIDTH (DATA_WIDTH),
      .LINE_WORDS (LINE_WORDS),
      .SETS       (SETS),
      .TAG_W      (TAG_W)
   ) u_store (
      .clk       (CLK),
      .data_we   (beat),
      .wr_index  (lk_idx),
      .wr_offset (beat_cnt),
      .wr_data   (DATA_FROM_L2),
      .tag_we    (last_beat),
      .wr_tag    (lk_tag),
      .rd_index  (lk_idx),
      .rd_offset (lk_off),
      .rd_data   (rd_data),
      .rd_tag    (rd_tag)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (do_miss)             state_nxt = REQUEST;
         REQUEST: if (ADDRESS_TO_L2_READY) state_nxt = REFILL;
         REFILL:  if (last_beat)           state_nxt = RESPOND;
         RESPOND: if (respond)             state_nxt = IDLE;
         default:                          state_nxt = IDLE;
      endcase
   end

   always_comb begin
      lookup    = (state == IDLE) && lk_vld && !INSTRUCTION_CACHE_STALL;
      do_hit    = lookup && hit;
      do_miss   = lookup && !hit;
      // A missing lookup stays in the register until its refill answers it.
      accept    = (state == IDLE) && !INSTRUCTION_CACHE_STALL && !do_miss;
      req_done  = (state == REQUEST) && ADDRESS_TO_L2_READY;
      beat      = (state == REFILL) && DATA_FROM_L2_VALID;
      last_beat = beat && (beat_cnt == LAST_BEAT);
      respond   = (state == RESPOND) && !INSTRUCTION_CACHE_STALL;
      flush_now = ((state == IDLE) && FLUSH) || (respond && (flush_pend || FLUSH));
   end

   // The line being refilled is invalidated up front so a torn line can never hit.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         line_vld <= '0;
      end else if (flush_now) begin
         line_vld <= '0;
      end else begin
         if (do_miss)   line_vld[lk_idx] <= LOW;
         if (last_beat) line_vld[lk_idx] <= HIGH;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         lk_addr                 <= '0;
         lk_vld                  <= LOW;
         flush_pend              <= LOW;
         beat_cnt                <= '0;
         INSTRUCTION             <= '0;
         INSTRUCTION_CACHE_READY <= LOW;
         ADDRESS_TO_L2           <= '0;
         ADDRESS_TO_L2_VALID     <= LOW;
      end else begin
         if (respond) begin
            lk_vld <= LOW;
         end else if (accept) begin
            lk_vld <= PC_VALID;
            if (PC_VALID) lk_addr <= PC[ADDRESS_WIDTH-1:2];
         end

         if (respond)                        flush_pend <= LOW;
         else if (FLUSH && (state != IDLE))  flush_pend <= HIGH;

         if (req_done)  beat_cnt <= '0;
         else if (beat) beat_cnt <= beat_cnt + OFF_W'(1);

         if (do_hit || respond) begin
            INSTRUCTION             <= rd_data;
            INSTRUCTION_CACHE_READY <= HIGH;
         end else if ((state == IDLE) && !INSTRUCTION_CACHE_STALL) begin
            INSTRUCTION_CACHE_READY <= LOW;
         end

         if (do_miss) begin
            ADDRESS_TO_L2       <= {lk_addr[WA_W-1:OFF_W], (OFF_W + 2)'(0)};
            ADDRESS_TO_L2_VALID <= HIGH;
         end else if (req_done) begin
            ADDRESS_TO_L2_VALID <= LOW;
         end
      end
   end

endmodule

// File: tb/tb_parametric_instruction_cache.sv
// Directed stimulus with a queue scoreboard for fetched words and L2 request addresses.
module tb_parametric_instruction_cache;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [31:0] PC;
   logic        PC_VALID;
   logic        INSTRUCTION_CACHE_STALL;
   logic        FLUSH;
   logic [31:0] INSTRUCTION;
   logic        INSTRUCTION_CACHE_READY;
   logic [31:0] ADDRESS_TO_L2;
   logic        ADDRESS_TO_L2_VALID;
   logic        ADDRESS_TO_L2_READY;
   logic [31:0] DATA_FROM_L2;
   logic        DATA_FROM_L2_VALID;

   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_q [$];
   logic [31:0] l2_q  [$];
   logic        stall_q = 1'b0;

   parametric_instruction_cache dut (
      .CLK                     (CLK),
      .RST_N                   (RST_N),
      .PC                      (PC),
      .PC_VALID                (PC_VALID),
      .INSTRUCTION_CACHE_STALL (INSTRUCTION_CACHE_STALL),
      .FLUSH                   (FLUSH),
      .INSTRUCTION             (INSTRUCTION),
      .INSTRUCTION_CACHE_READY (INSTRUCTION_CACHE_READY),
      .ADDRESS_TO_L2           (ADDRESS_TO_L2),
      .ADDRESS_TO_L2_VALID     (ADDRESS_TO_L2_VALID),
      .ADDRESS_TO_L2_READY     (ADDRESS_TO_L2_READY),
      .DATA_FROM_L2            (DATA_FROM_L2),
      .DATA_FROM_L2_VALID      (DATA_FROM_L2_VALID)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) stall_q = INSTRUCTION_CACHE_STALL;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: a fresh word is presented when READY is high after an unstalled edge.
   initial forever begin
      @(negedge CLK);
      if (INSTRUCTION_CACHE_READY && !stall_q) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_delivery: got 0x%0h with nothing expected", INSTRUCTION);
         end else begin
            check("instruction", INSTRUCTION, exp_q.pop_front());
         end
      end
      if (ADDRESS_TO_L2_VALID && ADDRESS_TO_L2_READY) begin
         if (l2_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_l2_request: got 0x%0h with nothing expected", ADDRESS_TO_L2);
         end else begin
            check("l2_address", ADDRESS_TO_L2, l2_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic fetch(input logic [31:0] pc);
      PC       = pc;
      PC_VALID = 1'b1;
      tick();
      PC_VALID = 1'b0;
   endtask

   task automatic miss_fetch(input logic [31:0] pc, input logic [31:0] line);
      l2_q.push_back(line);
      fetch(pc);
      tick();
      check("miss_ready_low", INSTRUCTION_CACHE_READY, 0);
      check("miss_req_valid", ADDRESS_TO_L2_VALID, 1);
      check("miss_req_addr", ADDRESS_TO_L2, line);
   endtask

   task automatic refill(input logic [31:0] line, input int delay, input bit gap,
                         input logic [31:0] base, input int flush_beat);
      for (int d = 0; d < delay; d++) begin
         check("req_hold_valid", ADDRESS_TO_L2_VALID, 1);
         check("req_hold_addr", ADDRESS_TO_L2, line);
         tick();
      end
      ADDRESS_TO_L2_READY = 1'b1;
      tick();
      ADDRESS_TO_L2_READY = 1'b0;
      check("req_valid_drop", ADDRESS_TO_L2_VALID, 0);
      for (int i = 0; i < 4; i++) begin
         if (gap && i > 0) begin
            tick();
            check("refill_ready_low", INSTRUCTION_CACHE_READY, 0);
         end
         DATA_FROM_L2       = base + 32'(i);
         DATA_FROM_L2_VALID = 1'b1;
         FLUSH              = (i == flush_beat);
         tick();
         DATA_FROM_L2_VALID = 1'b0;
         FLUSH              = 1'b0;
      end
      tick();
   endtask

   initial begin
      PC = '0;
      PC_VALID = 1'b0;
      INSTRUCTION_CACHE_STALL = 1'b0;
      FLUSH = 1'b0;
      ADDRESS_TO_L2_READY = 1'b0;
      DATA_FROM_L2 = '0;
      DATA_FROM_L2_VALID = 1'b0;
      tick();
      tick();
      check("rst_ready", INSTRUCTION_CACHE_READY, 0);
      check("rst_instruction", INSTRUCTION, 0);
      check("rst_req_valid", ADDRESS_TO_L2_VALID, 0);
      check("rst_req_addr", ADDRESS_TO_L2, 0);
      RST_N = 1'b1;
      tick();

      // Cold miss, then the rest of the line as back-to-back hits.
      exp_q.push_back(32'hA0);
      miss_fetch(32'h100, 32'h100);
      refill(32'h100, 0, 1'b0, 32'hA0, -1);
      exp_q.push_back(32'hA1);
      exp_q.push_back(32'hA2);
      exp_q.push_back(32'hA3);
      fetch(32'h104);
      fetch(32'h108);
      fetch(32'h10C);

      // Same index, new tag: slow L2 handshake and gapped beats.
      exp_q.push_back(32'hB1);
      miss_fetch(32'h504, 32'h500);
      refill(32'h500, 5, 1'b1, 32'hB0, -1);
      exp_q.push_back(32'hB2);
      fetch(32'h508);

      // 0x100 was evicted; flush arrives on the second beat of its refill.
      exp_q.push_back(32'hC0);
      miss_fetch(32'h100, 32'h100);
      refill(32'h100, 0, 1'b0, 32'hC0, 1);
      exp_q.push_back(32'hD1);
      miss_fetch(32'h104, 32'h100);
      refill(32'h100, 0, 1'b0, 32'hD0, -1);

      // Hit, then stall with a new PC on the bus.
      exp_q.push_back(32'hD2);
      fetch(32'h108);
      tick();
      INSTRUCTION_CACHE_STALL = 1'b1;
      PC = 32'h10C;
      PC_VALID = 1'b1;
      for (int s = 0; s < 3; s++) begin
         tick();
         check("stall_instruction", INSTRUCTION, 32'hD2);
         check("stall_ready", INSTRUCTION_CACHE_READY, 1);
      end
      INSTRUCTION_CACHE_STALL = 1'b0;
      PC_VALID = 1'b0;
      tick();
      check("post_stall_ready", INSTRUCTION_CACHE_READY, 0);
      tick();
      check("post_stall_ready2", INSTRUCTION_CACHE_READY, 0);

      // Reset in the middle of a refill.
      miss_fetch(32'h200, 32'h200);
      ADDRESS_TO_L2_READY = 1'b1;
      tick();
      ADDRESS_TO_L2_READY = 1'b0;
      for (int b = 0; b < 2; b++) begin
         DATA_FROM_L2 = 32'hF0 + 32'(b);
         DATA_FROM_L2_VALID = 1'b1;
         tick();
      end
      DATA_FROM_L2_VALID = 1'b0;
      RST_N = 1'b0;
      #1;
      check("midrst_req_valid", ADDRESS_TO_L2_VALID, 0);
      check("midrst_ready", INSTRUCTION_CACHE_READY, 0);
      check("midrst_instruction", INSTRUCTION, 0);
      tick();
      RST_N = 1'b1;
      DATA_FROM_L2_VALID = 1'b1;
      tick();
      tick();
      DATA_FROM_L2_VALID = 1'b0;
      check("after_rst_ready", INSTRUCTION_CACHE_READY, 0);
      exp_q.push_back(32'hE2);
      miss_fetch(32'h108, 32'h100);
      refill(32'h100, 0, 1'b0, 32'hE0, -1);

      tick();
      tick();
      check("words_outstanding", exp_q.size(), 0);
      check("requests_outstanding", l2_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
